srg_alu_arbiter: RTL and testbench
==================================

SRG_ALU_ARBITER -- requirements
Module: srg_alu_arbiter

Interface
REQ-001 SHALL use one clock and one reset: clk; reset is synchronous, active-high.
REQ-002 SHALL expose parameter DATA_W, default 32, ALU operand/result width; only 32 is supported.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 reqN_valid  input  1  port N (N=0,1) request present.
REQ-006 reqN_ready  output  1  port N request accepted this cycle.
REQ-007 reqN_a, reqN_b  input  32  port N operands.
REQ-008 reqN_op  input  3  port N opcode (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
REQ-009 rspN_valid  output  1  port N response held.
REQ-010 rspN_ready  input  1  port N consumer takes response.
REQ-011 rspN_result  output  32  registered ALU result.
REQ-012 rspN_overflow  output  1  registered ALU Overflow.
REQ-013 rspN_err  output  1  opcode was illegal (011, 100, 101).
REQ-014 alu_a, alu_b  output  32  operands driven to the shared combinational ALU.
REQ-015 alu_op  output  3  OperationSelect driven to the ALU.
REQ-016 alu_result  input  32; alu_overflow  input  1  combinational ALU outputs.

Function
REQ-017 Each port SHALL have a response slot with states EMPTY and FULL.
REQ-018 Port N is eligible when reqN_valid=1 and its slot is EMPTY, or FULL with rspN_valid and rspN_ready both 1 in the same cycle.
REQ-019 At most one port SHALL be granted per cycle; reqN_ready is asserted combinationally for the granted port only.
REQ-020 Only one eligible port: it is granted.
REQ-021 Both eligible: the port named by the round-robin pointer rr is granted.
REQ-022 After any grant, rr SHALL point to the non-granted port; with no grant, rr holds.
REQ-023 The granted request's a, b and op drive alu_a, alu_b and alu_op in the grant cycle; with no grant, drive all zeros.
REQ-024 On grant with a legal op, the slot SHALL load alu_result and alu_overflow, clear err and go FULL at the next edge; the response is visible one cycle after acceptance.
REQ-025 On grant with an illegal op, the slot SHALL load result 0, overflow 0 and err 1, and go FULL.
REQ-026 rspN_overflow SHALL be forced to 0 for AND and OR ops.
REQ-027 A FULL slot SHALL hold result, overflow and err stable until rspN_ready=1.
REQ-028 Drain without a new grant: the slot goes EMPTY. Drain with a same-cycle grant: the slot reloads and stays FULL, giving one result per cycle per port.
REQ-029 reqN_ready SHALL NOT depend on reqN_ready of the other port, and SHALL NOT depend combinationally on alu_result.
REQ-030 Requesters SHALL hold reqN_* stable while valid and not ready; the block does not check this.

Reset
REQ-031 reset SHALL set both slots EMPTY, rspN_valid=0, result 0, overflow 0, err 0 and rr=0.
REQ-032 reset mid-operation SHALL drop held responses; reqN_ready=0 while reset=1.

Structure
REQ-033 Opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT) and slot-state encodings SHALL live in the shared package srg_alu_pkg.
REQ-034 The per-port response slot SHALL be the sub-module srg_alu_rsp_slot, instantiated twice.
REQ-035 The ALU SHALL NOT be instantiated inside this block; the top-level wires it.

Verification
REQ-036 Port 0 alone: a=5, b=3, op=010 -> req0_ready in the same cycle; next cycle rsp0_valid with result 8, overflow 0.
REQ-037 Both ports request every cycle with rsp ready tied to 1 -> grants alternate 0,1,0,1 starting at port 0; no port is starved.
REQ-038 SUB with a=32'h80000000, b=1 -> rsp overflow 1; SLT with a=2, b=7 -> result follows the ALU input, check against the ALU model.
REQ-039 Port 1 slot FULL with rsp1_ready=0 and port 1 still requesting -> req1_ready=0 and port 0 is granted every cycle; raising rsp1_ready gives drain and reload in the same cycle.
REQ-040 op=101 -> rsp err 1, result 0, overflow 0; then reset asserted with both slots FULL -> next cycle both rsp valid 0 and rr=0.

Source files
------------

// File: rtl/srg_alu_pkg.sv
// Shared opcode constants, response-slot state encoding and opcode helpers
// for the two-port ALU arbiter.
package srg_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    // Logic ops have no meaningful overflow; only arithmetic ops pass it on.
    function automatic logic op_has_ovf(input logic [2:0] op);
        return op_is_legal(op) && (op != OP_AND) && (op != OP_OR);
    endfunction

endpackage

// File: rtl/srg_alu_rsp_slot.sv
// One-entry response holding register for a single requester port.
// Loads on grant, holds until the consumer takes it; drain and reload may coincide.
module srg_alu_rsp_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_overflow_i,
    input  logic              rsp_ready_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_overflow_o,
    output logic              rsp_err_o
);
    import srg_alu_pkg::*;

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SLOT_EMPTY;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        if (load_i) begin
            state_d = SLOT_FULL;
            if (op_is_legal(op_i)) begin
                result_d = alu_result_i;
                ovf_d    = op_has_ovf(op_i) & alu_overflow_i;
                err_d    = 1'b0;
            end else begin
                result_d = '0;
                ovf_d    = 1'b0;
                err_d    = 1'b1;
            end
        end else if (state_q == SLOT_FULL && rsp_ready_i) begin
            state_d = SLOT_EMPTY;
        end
    end

    assign rsp_valid_o    = (state_q == SLOT_FULL);
    assign rsp_result_o   = result_q;
    assign rsp_overflow_o = ovf_q;
    assign rsp_err_o      = err_q;

endmodule

// File: rtl/srg_alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two ports;
// the granted port's operands drive the ALU and its result lands in that port's slot.
module srg_alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_overflow,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_overflow,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow
);
    import srg_alu_pkg::*;

    logic rr_q, rr_d;
    logic elig0, elig1;
    logic grant0, grant1;

    // A full slot is eligible only when it is being drained this very cycle.
    assign elig0  = !reset && req0_valid && (!rsp0_valid || rsp0_ready);
    assign elig1  = !reset && req1_valid && (!rsp1_valid || rsp1_ready);
    assign grant0 = elig0 && (!elig1 || !rr_q);
    assign grant1 = elig1 && (!elig0 ||  rr_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 3'b000;
        rr_d   = rr_q;
        if (grant0) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
            rr_d   = 1'b1;
        end else if (grant1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
            rr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end

    srg_alu_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk            (clk),
        .reset          (reset),
        .load_i         (grant0),
        .op_i           (req0_op),
        .alu_result_i   (alu_result),
        .alu_overflow_i (alu_overflow),
        .rsp_ready_i    (rsp0_ready),
        .rsp_valid_o    (rsp0_valid),
        .rsp_result_o   (rsp0_result),
        .rsp_overflow_o (rsp0_overflow),
        .rsp_err_o      (rsp0_err)
    );

    srg_alu_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk            (clk),
        .reset          (reset),
        .load_i         (grant1),
        .op_i           (req1_op),
        .alu_result_i   (alu_result),
        .alu_overflow_i (alu_overflow),
        .rsp_ready_i    (rsp1_ready),
        .rsp_valid_o    (rsp1_valid),
        .rsp_result_o   (rsp1_result),
        .rsp_overflow_o (rsp1_overflow),
        .rsp_err_o      (rsp1_err)
    );

endmodule

// File: tb/tb_srg_alu_arbiter.sv
// Directed bench for srg_alu_arbiter with a behavioural ALU model closing the loop.
module tb_srg_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_overflow, rsp0_err;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_overflow, rsp1_err;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
    logic [2:0]  req0_op, req1_op, alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_overflow;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    srg_alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_overflow(rsp0_overflow), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_overflow(rsp1_overflow), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow)
    );

    // External ALU. Logic ops and illegal codes deliberately raise overflow
    // (and illegal codes return junk) so that masking in the DUT is exercised.
    logic [31:0] sum, diff;
    always_comb begin
        sum          = alu_a + alu_b;
        diff         = alu_a - alu_b;
        alu_result   = 32'hDEAD_BEEF;
        alu_overflow = 1'b1;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                alu_result   = sum;
                alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            3'b110: begin
                alu_result   = diff;
                alu_overflow = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            3'b111: begin
                alu_result   = {31'b0, $signed(alu_a) < $signed(alu_b)};
                alu_overflow = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic drv1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    endtask

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        drv0(1'b1, 32'd1, 32'd1, 3'b010);
        drv1(1'b1, 32'd1, 32'd1, 3'b010);
        @(negedge clk);
        #1;
        chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
        cyc();
        chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        chk("rst_rsp0_result", rsp0_result, 32'd0);
        chk("rst_rsp1_err", {31'b0, rsp1_err}, 32'd0);

        // Port 0 alone: 5 + 3
        reset = 1'b0;
        drv0(1'b1, 32'd5, 32'd3, 3'b010);
        drv1(1'b0, 32'd0, 32'd0, 3'b000);
        #1;
        chk("p0_alone_ready", {31'b0, req0_ready}, 32'd1);
        chk("p0_alone_ready1", {31'b0, req1_ready}, 32'd0);
        chk("p0_alone_alu_a", alu_a, 32'd5);
        chk("p0_alone_alu_op", {29'b0, alu_op}, 32'd2);
        cyc();
        drv0(1'b1, 32'd1, 32'd1, 3'b010);
        #1;
        chk("add_rsp_valid", {31'b0, rsp0_valid}, 32'd1);
        chk("add_rsp_result", rsp0_result, 32'd8);
        chk("add_rsp_ovf", {31'b0, rsp0_overflow}, 32'd0);
        chk("full_blocks_req0", {31'b0, req0_ready}, 32'd0);
        chk("idle_alu_a_zero", alu_a, 32'd0);
        cyc();
        chk("hold_result", rsp0_result, 32'd8);
        chk("hold_valid", {31'b0, rsp0_valid}, 32'd1);
        rsp0_ready = 1'b1;
        #1;
        chk("drain_reload_ready", {31'b0, req0_ready}, 32'd1);
        cyc();
        chk("reload_result", rsp0_result, 32'd2);
        chk("reload_valid", {31'b0, rsp0_valid}, 32'd1);
        drv0(1'b0, 32'd0, 32'd0, 3'b000);
        cyc();
        chk("drain_empty", {31'b0, rsp0_valid}, 32'd0);

        // Port 1: SUB overflow then SLT
        rsp1_ready = 1'b0;
        drv1(1'b1, 32'h8000_0000, 32'd1, 3'b110);
        #1;
        chk("sub_grant", {31'b0, req1_ready}, 32'd1);
        cyc();
        chk("sub_result", rsp1_result, 32'h7FFF_FFFF);
        chk("sub_ovf", {31'b0, rsp1_overflow}, 32'd1);
        rsp1_ready = 1'b1;
        drv1(1'b1, 32'd2, 32'd7, 3'b111);
        cyc();
        chk("slt_result", rsp1_result, 32'd1);
        chk("slt_ovf", {31'b0, rsp1_overflow}, 32'd0);
        drv1(1'b0, 32'd0, 32'd0, 3'b000);
        cyc();
        chk("p1_empty", {31'b0, rsp1_valid}, 32'd0);

        // Both ports every cycle, alternating from port 0
        for (int k = 0; k < 4; k++) begin
            drv0(1'b1, 32'hF0F0_0000 | k, 32'hFF00_FFFF, 3'b000);
            drv1(1'b1, k, 32'h100, 3'b001);
            #1;
            chk($sformatf("rr%0d_req0_ready", k), {31'b0, req0_ready}, {31'b0, (k % 2) == 0});
            chk($sformatf("rr%0d_req1_ready", k), {31'b0, req1_ready}, {31'b0, (k % 2) == 1});
            cyc();
            if ((k % 2) == 0) begin
                chk($sformatf("rr%0d_and_result", k), rsp0_result, 32'hF000_0000 | k);
                chk($sformatf("rr%0d_and_ovf", k), {31'b0, rsp0_overflow}, 32'd0);
                chk($sformatf("rr%0d_other_idle", k), {31'b0, rsp1_valid}, 32'd0);
            end else begin
                chk($sformatf("rr%0d_or_result", k), rsp1_result, 32'h100 | k);
                chk($sformatf("rr%0d_or_ovf", k), {31'b0, rsp1_overflow}, 32'd0);
                chk($sformatf("rr%0d_other_idle", k), {31'b0, rsp0_valid}, 32'd0);
            end
        end
        drv0(1'b0, 32'd0, 32'd0, 3'b000);
        drv1(1'b0, 32'd0, 32'd0, 3'b000);
        cyc();

        // Port 1 stalled full: port 0 wins every cycle, then drain+reload
        rsp1_ready = 1'b0;
        drv1(1'b1, 32'd10, 32'd20, 3'b010);
        cyc();
        chk("stall_fill", rsp1_result, 32'd30);
        drv1(1'b1, 32'd7, 32'd8, 3'b010);
        for (int k = 0; k < 2; k++) begin
            drv0(1'b1, 32'd100 + k, 32'd1, 3'b010);
            #1;
            chk($sformatf("stall%0d_req1_ready", k), {31'b0, req1_ready}, 32'd0);
            chk($sformatf("stall%0d_req0_ready", k), {31'b0, req0_ready}, 32'd1);
            cyc();
            chk($sformatf("stall%0d_rsp0", k), rsp0_result, 32'd101 + k);
            chk($sformatf("stall%0d_rsp1_hold", k), rsp1_result, 32'd30);
        end
        rsp1_ready = 1'b1;
        #1;
        chk("unstall_req1_ready", {31'b0, req1_ready}, 32'd1);
        chk("unstall_req0_ready", {31'b0, req0_ready}, 32'd0);
        cyc();
        chk("unstall_rsp1", rsp1_result, 32'd15);
        chk("unstall_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);

        // Illegal opcode, then reset with both slots full
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        drv0(1'b1, 32'd5, 32'd6, 3'b101);
        drv1(1'b0, 32'd0, 32'd0, 3'b000);
        cyc();
        chk("ill_err", {31'b0, rsp0_err}, 32'd1);
        chk("ill_result", rsp0_result, 32'd0);
        chk("ill_ovf", {31'b0, rsp0_overflow}, 32'd0);
        chk("ill_p1_full", {31'b0, rsp1_valid}, 32'd1);
        reset = 1'b1;
        drv0(1'b1, 32'd1, 32'd2, 3'b010);
        drv1(1'b1, 32'd3, 32'd4, 3'b010);
        #1;
        chk("midrst_req0_ready", {31'b0, req0_ready}, 32'd0);
        chk("midrst_req1_ready", {31'b0, req1_ready}, 32'd0);
        cyc();
        chk("midrst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("midrst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        chk("midrst_err", {31'b0, rsp0_err}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_rr_req0", {31'b0, req0_ready}, 32'd1);
        chk("post_rst_rr_req1", {31'b0, req1_ready}, 32'd0);
        cyc();
        chk("post_rst_result", rsp0_result, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
